// File: rtl/jt900h_div_pkg.sv
// Shared definitions for the jt900h sequential divider: FSM encoding,
// iteration counts and the bit positions used to pack quotient/remainder.
package jt900h_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } div_state_t;

    localparam int          CNT_W  = 5;
    localparam logic [4:0]  N_WORD = 5'd16;
    localparam logic [4:0]  N_BYTE = 5'd8;

    localparam int QUO_LSB   = 0;
    localparam int REM_LSB_W = 16;
    localparam int REM_LSB_B = 8;
    localparam int HI_LSB_B  = 16;

    // Byte mode passes the untouched upper half of the dividend through.
    function automatic logic [31:0] pack_rslt(
        input logic        byte_mode,
        input logic [15:0] hi,
        input logic [15:0] rem,
        input logic [15:0] quo
    );
        logic [31:0] r;
        r = '0;
        if (byte_mode) begin
            r[HI_LSB_B  +: 16] = hi;
            r[REM_LSB_B +: 8]  = rem[7:0];
            r[QUO_LSB   +: 8]  = quo[7:0];
        end else begin
            r[REM_LSB_W +: 16] = rem;
            r[QUO_LSB   +: 16] = quo;
        end
        return r;
    endfunction

endpackage

// File: rtl/jt900h_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module jt900h_div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0]   shifted;
    logic [W+1:0] diff;
    logic         unused_diff;

    assign shifted     = {rem_i, bit_i};
    // Extra headroom bit so the borrow is exact even when rem_i >= dvs_i.
    assign diff        = {1'b0, shifted} - {2'b00, dvs_i};
    assign q_o         = ~diff[W+1];
    assign rem_o       = q_o ? diff[W-1:0] : shifted[W-1:0];
    assign unused_diff = diff[W];

endmodule

// File: rtl/jt900h_div.sv
// Radix-2 restoring divider for DIV/DIVS: 32/16 word or 16/8 byte mode,
// constant latency, packed {remainder, quotient} result plus overflow flag.
module jt900h_div
    import jt900h_div_pkg::*;
(
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        start,
    input  logic        bs,
    input  logic        sgn,
    input  logic [31:0] op0,
    input  logic [31:0] op1,
    output logic        busy,
    output logic        done,
    output logic [31:0] rslt,
    output logic        vo
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      rem_q, rem_d;
    logic [15:0]      sh_q, sh_d;
    logic [15:0]      quo_q, quo_d;
    logic [15:0]      dvs_q, dvs_d;
    logic [31:0]      op0_q, op0_d;
    logic             bs_q, bs_d;
    logic             sgn_q, sgn_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             quo_neg_q, quo_neg_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      rslt_q, rslt_d;
    logic             vo_q, vo_d;
    logic             done_q, done_d;

    logic             dvd_neg, dvs_neg;
    logic [31:0]      dvd_abs;
    logic [15:0]      dvs_abs;
    logic [15:0]      rem_init, sh_init, dvs_init;
    logic [15:0]      step_rem;
    logic             step_q;
    logic [15:0]      quo_s, rem_s, quo_lim;
    logic             ovf_all;
    logic             unused_op1;

    assign unused_op1 = ^op1[31:16];

    // Operand conditioning for the start cycle.
    always_comb begin
        dvd_neg  = sgn & (bs ? op0[15] : op0[31]);
        dvs_neg  = sgn & (bs ? op1[7]  : op1[15]);
        dvd_abs  = dvd_neg ? (32'd0 - op0) : op0;
        dvs_abs  = dvs_neg ? (16'd0 - op1[15:0]) : op1[15:0];
        rem_init = bs ? {8'h00, dvd_abs[15:8]} : dvd_abs[31:16];
        sh_init  = bs ? {dvd_abs[7:0], 8'h00}  : dvd_abs[15:0];
        dvs_init = bs ? {8'h00, dvs_abs[7:0]}  : dvs_abs;
    end

    jt900h_div_step #(.W(16)) u_step (
        .rem_i (rem_q),
        .bit_i (sh_q[15]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Sign fix-up and signed range limit for the final cycle.
    always_comb begin
        quo_s   = quo_neg_q ? (16'd0 - quo_q) : quo_q;
        rem_s   = dvd_neg_q ? (16'd0 - rem_q) : rem_q;
        if (bs_q)
            quo_lim = quo_neg_q ? 16'h0080 : 16'h007F;
        else
            quo_lim = quo_neg_q ? 16'h8000 : 16'h7FFF;
        ovf_all = ovf_q | (sgn_q & (quo_q > quo_lim));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        sh_d      = sh_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        op0_d     = op0_q;
        bs_d      = bs_q;
        sgn_d     = sgn_q;
        dvd_neg_d = dvd_neg_q;
        quo_neg_d = quo_neg_q;
        ovf_d     = ovf_q;
        rslt_d    = rslt_q;
        vo_d      = vo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op0_d     = op0;
                    bs_d      = bs;
                    sgn_d     = sgn;
                    dvd_neg_d = dvd_neg;
                    quo_neg_d = dvd_neg ^ dvs_neg;
                    rem_d     = rem_init;
                    sh_d      = sh_init;
                    dvs_d     = dvs_init;
                    quo_d     = 16'h0000;
                    // Covers divide-by-zero; the loop still runs for fixed latency.
                    ovf_d     = (rem_init >= dvs_init);
                    cnt_d     = bs ? N_BYTE : N_WORD;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                sh_d  = {sh_q[14:0], 1'b0};
                quo_d = {quo_q[14:0], step_q};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1)
                    state_d = S_FIX;
            end
            S_FIX: begin
                vo_d    = ovf_all;
                rslt_d  = ovf_all ? op0_q
                                  : pack_rslt(bs_q, op0_q[31:16], rem_s, quo_s);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            sh_q      <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            op0_q     <= '0;
            bs_q      <= 1'b0;
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            quo_neg_q <= 1'b0;
            ovf_q     <= 1'b0;
            rslt_q    <= '0;
            vo_q      <= 1'b0;
            done_q    <= 1'b0;
        end else if (cen) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            sh_q      <= sh_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            op0_q     <= op0_d;
            bs_q      <= bs_d;
            sgn_q     <= sgn_d;
            dvd_neg_q <= dvd_neg_d;
            quo_neg_q <= quo_neg_d;
            ovf_q     <= ovf_d;
            rslt_q    <= rslt_d;
            vo_q      <= vo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign rslt = rslt_q;
    assign vo   = vo_q;

endmodule

// File: tb/tb_jt900h_div.sv
// Directed self-checking bench for jt900h_div: one task per scenario,
// expected values worked out by hand from the divider's arithmetic.
module tb_jt900h_div;

    logic        rst;
    logic        clk;
    logic        cen;
    logic        start;
    logic        bs;
    logic        sgn;
    logic [31:0] op0;
    logic [31:0] op1;
    logic        busy;
    logic        done;
    logic [31:0] rslt;
    logic        vo;

    int tests_run;
    int tests_failed;

    jt900h_div dut (
        .rst   (rst),
        .clk   (clk),
        .cen   (cen),
        .start (start),
        .bs    (bs),
        .sgn   (sgn),
        .op0   (op0),
        .op1   (op1),
        .busy  (busy),
        .done  (done),
        .rslt  (rslt),
        .vo    (vo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: issue one division and report latency/result observed.
    task automatic do_div(
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic        b_s,
        input  logic        s,
        input  logic        stall,
        output int          lat,
        output logic [31:0] r,
        output logic        v,
        output int          busy_bad
    );
        op0 = a; op1 = b; bs = b_s; sgn = s; start = 1'b1; cen = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 0;
        busy_bad = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            cen = (stall && (cyc % 2 == 0)) ? 1'b0 : 1'b1;
            tick();
            if (cen) lat++;
            if (busy === done) busy_bad++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) lat = 999;
        r   = rslt;
        v   = vo;
        cen = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; cen = 1'b1; bs = 1'b0; sgn = 1'b0;
        op0 = 32'h0001_0005; op1 = 32'h0000_0010;
        tick();
        tick();
        tests_run += 4;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        if (rslt !== 32'h0) begin tests_failed++; $display("FAIL reset_rslt: got %h want 00000000", rslt); end
        if (vo !== 1'b0) begin tests_failed++; $display("FAIL reset_vo: got %b want 0", vo); end
        $display("[TB] reset: busy=%b done=%b rslt=%h vo=%b", busy, done, rslt, vo);
        rst = 1'b0; cen = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL start_without_cen: busy got %b want 0", busy); end
        $display("[TB] start with cen low: busy=%b", busy);
        start = 1'b0; cen = 1'b1;
        tick();
    endtask

    task automatic test_unsigned_word();
        int lat; int bb; logic [31:0] r; logic v;
        do_div(32'h0001_0005, 32'h0000_0010, 1'b0, 1'b0, 1'b0, lat, r, v, bb);
        tests_run += 4;
        if (r !== 32'h0005_1000) begin tests_failed++; $display("FAIL uword_rslt: got %h want 00051000", r); end
        if (v !== 1'b0) begin tests_failed++; $display("FAIL uword_vo: got %b want 0", v); end
        if (lat !== 17) begin tests_failed++; $display("FAIL uword_latency: got %0d want 17", lat); end
        if (bb !== 0) begin tests_failed++; $display("FAIL uword_busy: %0d samples with busy==done, want 0", bb); end
        $display("[TB] uword 00010005/0010: rslt=%h vo=%b lat=%0d", r, v, lat);
    endtask

    task automatic test_unsigned_byte();
        int lat; int bb; logic [31:0] r; logic v;
        do_div(32'hABCD_0064, 32'h0000_0007, 1'b1, 1'b0, 1'b0, lat, r, v, bb);
        tests_run += 4;
        if (r !== 32'hABCD_020E) begin tests_failed++; $display("FAIL ubyte_rslt: got %h want ABCD020E", r); end
        if (v !== 1'b0) begin tests_failed++; $display("FAIL ubyte_vo: got %b want 0", v); end
        if (lat !== 9) begin tests_failed++; $display("FAIL ubyte_latency: got %0d want 9", lat); end
        if (bb !== 0) begin tests_failed++; $display("FAIL ubyte_busy: %0d samples with busy==done, want 0", bb); end
        $display("[TB] ubyte ABCD0064/07: rslt=%h vo=%b lat=%0d", r, v, lat);
    endtask

    task automatic test_signed_word();
        int lat; int bb; logic [31:0] r; logic v;
        do_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b1, 1'b0, lat, r, v, bb);
        tests_run += 3;
        if (r !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL sword_rslt: got %h want FFFFFFFD", r); end
        if (v !== 1'b0) begin tests_failed++; $display("FAIL sword_vo: got %b want 0", v); end
        if (lat !== 17) begin tests_failed++; $display("FAIL sword_latency: got %0d want 17", lat); end
        $display("[TB] sword -7/2: rslt=%h vo=%b lat=%0d", r, v, lat);
        do_div(32'hFFFF_8000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, lat, r, v, bb);
        tests_run += 2;
        if (r !== 32'h0000_8000) begin tests_failed++; $display("FAIL sword_min_rslt: got %h want 00008000", r); end
        if (v !== 1'b0) begin tests_failed++; $display("FAIL sword_min_vo: got %b want 0", v); end
        $display("[TB] sword -32768/1: rslt=%h vo=%b", r, v);
        do_div(32'h0000_FF80, 32'h0000_0001, 1'b1, 1'b1, 1'b0, lat, r, v, bb);
        tests_run += 2;
        if (r !== 32'h0000_0080) begin tests_failed++; $display("FAIL sbyte_min_rslt: got %h want 00000080", r); end
        if (v !== 1'b0) begin tests_failed++; $display("FAIL sbyte_min_vo: got %b want 0", v); end
        $display("[TB] sbyte -128/1: rslt=%h vo=%b", r, v);
    endtask

    task automatic test_overflow();
        int lat; int bb; logic [31:0] r; logic v;
        do_div(32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b0, lat, r, v, bb);
        tests_run += 3;
        if (r !== 32'h1234_5678) begin tests_failed++; $display("FAIL div0_rslt: got %h want 12345678", r); end
        if (v !== 1'b1) begin tests_failed++; $display("FAIL div0_vo: got %b want 1", v); end
        if (lat !== 17) begin tests_failed++; $display("FAIL div0_latency: got %0d want 17", lat); end
        $display("[TB] div0 12345678/0: rslt=%h vo=%b lat=%0d", r, v, lat);
        do_div(32'h0002_0000, 32'h0000_0002, 1'b0, 1'b0, 1'b0, lat, r, v, bb);
        tests_run += 2;
        if (r !== 32'h0002_0000) begin tests_failed++; $display("FAIL uovf_rslt: got %h want 00020000", r); end
        if (v !== 1'b1) begin tests_failed++; $display("FAIL uovf_vo: got %b want 1", v); end
        $display("[TB] uovf 00020000/2: rslt=%h vo=%b", r, v);
        do_div(32'hFFFF_8000, 32'h0000_FFFF, 1'b0, 1'b1, 1'b0, lat, r, v, bb);
        tests_run += 2;
        if (r !== 32'hFFFF_8000) begin tests_failed++; $display("FAIL sovf_rslt: got %h want FFFF8000", r); end
        if (v !== 1'b1) begin tests_failed++; $display("FAIL sovf_vo: got %b want 1", v); end
        $display("[TB] sovf -32768/-1: rslt=%h vo=%b", r, v);
        do_div(32'h0000_FF80, 32'h0000_00FF, 1'b1, 1'b1, 1'b0, lat, r, v, bb);
        tests_run += 3;
        if (r !== 32'h0000_FF80) begin tests_failed++; $display("FAIL sbovf_rslt: got %h want 0000FF80", r); end
        if (v !== 1'b1) begin tests_failed++; $display("FAIL sbovf_vo: got %b want 1", v); end
        if (lat !== 9) begin tests_failed++; $display("FAIL sbovf_latency: got %0d want 9", lat); end
        $display("[TB] sbyte ovf -128/-1: rslt=%h vo=%b lat=%0d", r, v, lat);
    endtask

    task automatic test_reset_mid();
        int lat; int bb; int done_seen; logic [31:0] r; logic v;
        op0 = 32'h0012_3456; op1 = 32'h0000_1234; bs = 1'b0; sgn = 1'b0;
        start = 1'b1; cen = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run += 4;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL midrst_done: got %b want 0", done); end
        if (rslt !== 32'h0) begin tests_failed++; $display("FAIL midrst_rslt: got %h want 00000000", rslt); end
        if (vo !== 1'b0) begin tests_failed++; $display("FAIL midrst_vo: got %b want 0", vo); end
        $display("[TB] reset mid-op: busy=%b done=%b rslt=%h vo=%b", busy, done, rslt, vo);
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        tests_run++;
        if (done_seen !== 0) begin tests_failed++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
        do_div(32'h0012_3456, 32'h0000_1234, 1'b0, 1'b0, 1'b0, lat, r, v, bb);
        tests_run += 3;
        if (r !== 32'h0056_0100) begin tests_failed++; $display("FAIL midrst_fresh_rslt: got %h want 00560100", r); end
        if (v !== 1'b0) begin tests_failed++; $display("FAIL midrst_fresh_vo: got %b want 0", v); end
        if (lat !== 17) begin tests_failed++; $display("FAIL midrst_fresh_latency: got %0d want 17", lat); end
        $display("[TB] fresh after reset 00123456/1234: rslt=%h vo=%b lat=%0d", r, v, lat);
    endtask

    task automatic test_stall();
        int lat; int bb; logic [31:0] r; logic v;
        do_div(32'h0000_1234, 32'h0000_0012, 1'b0, 1'b0, 1'b1, lat, r, v, bb);
        tests_run += 4;
        if (r !== 32'h0010_0102) begin tests_failed++; $display("FAIL stall_rslt: got %h want 00100102", r); end
        if (v !== 1'b0) begin tests_failed++; $display("FAIL stall_vo: got %b want 0", v); end
        if (lat !== 17) begin tests_failed++; $display("FAIL stall_latency: got %0d want 17", lat); end
        if (bb !== 0) begin tests_failed++; $display("FAIL stall_busy: %0d samples with busy==done, want 0", bb); end
        $display("[TB] stall 1234/12: rslt=%h vo=%b lat=%0d", r, v, lat);
        cen = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL stall_done_frozen: got %b want 1", done); end
        cen = 1'b1;
        tick();
        tests_run += 2;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL done_one_cycle: got %b want 0", done); end
        if (rslt !== 32'h0010_0102) begin tests_failed++; $display("FAIL rslt_hold: got %h want 00100102", rslt); end
        $display("[TB] after done: done=%b rslt=%h", done, rslt);
    endtask

    task automatic test_ignored_start();
        int lat;
        op0 = 32'h0001_0005; op1 = 32'h0000_0010; bs = 1'b0; sgn = 1'b0;
        start = 1'b1; cen = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc == 5) begin
                start = 1'b1; op0 = 32'hFFFF_FFFF; op1 = 32'h0000_0001; bs = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) lat = 999;
        tests_run += 3;
        if (lat !== 17) begin tests_failed++; $display("FAIL ignstart_latency: got %0d want 17", lat); end
        if (rslt !== 32'h0005_1000) begin tests_failed++; $display("FAIL ignstart_rslt: got %h want 00051000", rslt); end
        if (vo !== 1'b0) begin tests_failed++; $display("FAIL ignstart_vo: got %b want 0", vo); end
        $display("[TB] ignored start: rslt=%h vo=%b lat=%0d", rslt, vo, lat);
        start = 1'b0; bs = 1'b0;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; cen = 1'b1; start = 1'b0; bs = 1'b0; sgn = 1'b0;
        op0 = 32'h0; op1 = 32'h0;
        test_reset();
        test_unsigned_word();
        test_unsigned_byte();
        test_signed_word();
        test_overflow();
        test_reset_mid();
        test_stall();
        test_ignored_start();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
